// File: rtl/sevseg_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// blank pattern and the active-low hex glyph table.
package sevseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} glyphs for 0..9, A, b, C, d, E, F
  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/sevseg_scan_ctrl_if.sv
// Display bus between the peripheral side (master) and the scan controller (slave):
// digit data/control in, segment and anode drives out.
interface sevseg_scan_ctrl_if #(
  parameter int N_DIGITS = 8
);

  logic [4*N_DIGITS-1:0] data_i;
  logic [N_DIGITS-1:0]   dp_i;
  logic [N_DIGITS-1:0]   digit_en_i;
  logic                  lzb_i;
  logic [6:0]            seg_o;
  logic                  dp_o;
  logic [N_DIGITS-1:0]   an_o;
  logic                  frame_o;

  modport master (
    output data_i, dp_i, digit_en_i, lzb_i,
    input  seg_o, dp_o, an_o, frame_o
  );

  modport slave (
    input  data_i, dp_i, digit_en_i, lzb_i,
    output seg_o, dp_o, an_o, frame_o
  );

endinterface

// File: rtl/sevseg_hex_decoder.sv
// Combinational nibble to active-low 7-segment glyph decoder.
module sevseg_hex_decoder
  import sevseg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg(nib_i);

endmodule

// File: rtl/sevseg_scan_ctrl.sv
// Round-robin scan driver for N common-anode digits on a shared segment bus,
// with per-slot dead time, per-frame shadow capture and leading-zero blanking.
module sevseg_scan_ctrl
  import sevseg_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  sevseg_scan_ctrl_if.slave  bus_if
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0] sh_data_q, sh_data_d;
  logic [N_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [N_DIGITS-1:0]   sh_en_q, sh_en_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_q, frame_d;

  logic                  slot_end_s;
  logic                  frame_end_s;
  logic [3:0]            nib_sel_s;
  logic                  dp_sel_s;
  logic                  blank_sel_s;
  logic                  zero_run_s;
  logic [N_DIGITS-1:0]   lzb_blank_s;
  logic [6:0]            dec_seg_s;

  sevseg_hex_decoder u_hex_decoder (
    .nib_i (nib_sel_s),
    .seg_o (dec_seg_s)
  );

  // Prescaler, scan index and frame-boundary shadow capture
  always_comb begin
    slot_end_s  = (cnt_q == CW'(REFRESH_DIV - 1));
    frame_end_s = slot_end_s && (idx_q == IW'(N_DIGITS - 1));
    cnt_d       = cnt_q + CW'(1);
    idx_d       = idx_q;
    sh_data_d   = sh_data_q;
    sh_dp_d     = sh_dp_q;
    sh_en_d     = sh_en_q;
    frame_d     = 1'b0;
    if (slot_end_s) begin
      cnt_d = '0;
      idx_d = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    if (frame_end_s) begin
      sh_data_d = bus_if.data_i;
      sh_dp_d   = bus_if.dp_i;
      sh_en_d   = bus_if.digit_en_i;
      frame_d   = 1'b1;
    end else begin
      frame_d   = 1'b0;
    end
  end

  // Selected-digit fields and leading-zero mask (scanned from the most significant digit)
  always_comb begin
    nib_sel_s   = 4'h0;
    dp_sel_s    = 1'b0;
    blank_sel_s = 1'b0;
    zero_run_s  = 1'b1;
    lzb_blank_s = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zero_run_s     = zero_run_s & (sh_data_q[4*k +: 4] == 4'h0);
      lzb_blank_s[k] = bus_if.lzb_i & zero_run_s & (k != 0);
    end
    for (int k = 0; k < N_DIGITS; k++) begin
      nib_sel_s   = (idx_q == IW'(k)) ? sh_data_q[4*k +: 4] : nib_sel_s;
      dp_sel_s    = (idx_q == IW'(k)) ? sh_dp_q[k]          : dp_sel_s;
      blank_sel_s = (idx_q == IW'(k)) ? lzb_blank_s[k]      : blank_sel_s;
    end
  end

  // Output drive: dead time at slot start, then the selected digit
  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (cnt_q >= CW'(BLANK_CYCLES)) begin
      for (int k = 0; k < N_DIGITS; k++) begin
        an_d[k] = (idx_q == IW'(k)) ? ~sh_en_q[k] : 1'b1;
      end
      seg_d = blank_sel_s ? SEG_BLANK : dec_seg_s;
      dp_d  = ~dp_sel_s;
    end else begin
      an_d  = '1;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      sh_data_q <= '0;
      sh_dp_q   <= '0;
      sh_en_q   <= '0;
      an_q      <= '1;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
      frame_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh_data_q <= sh_data_d;
      sh_dp_q   <= sh_dp_d;
      sh_en_q   <= sh_en_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      frame_q   <= frame_d;
    end
  end

  assign bus_if.an_o    = an_q;
  assign bus_if.seg_o   = seg_q;
  assign bus_if.dp_o    = dp_q;
  assign bus_if.frame_o = frame_q;

endmodule
